i2c_slave_target: RTL and testbench

Responder end of the team's I2C bus: a 7-bit-addressed I2C slave that pairs with the existing I2C master on the same `scl`/`sda` wires. It oversamples the bus on the system clock, detects START/STOP, matches its address, ACKs, and then accepts write bytes or returns read bytes. Byte data moves to and from local logic through a simple pulse/strobe interface.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_line_sync.sv | 30 +++
 rtl/i2c_slave_target.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_slave_target.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_slv_state_t;

    localparam int unsigned I2C_BITS_PER_BYTE = 8;
    localparam logic        I2C_RW_READ       = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus history flop for one bus line; reports level and edges.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    // Reset to the idle-high bus level so no edge is reported out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= line_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/i2c_slave_target.sv
// 7-bit addressed I2C slave: oversampled bus, ACKs own address, byte strobes to local logic.
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       addressed,
    output logic       busy,
    output logic       stop_det
);

    localparam logic [3:0] BYTE_CNT = 4'(I2C_BITS_PER_BYTE);
    localparam logic [3:0] LAST_TX  = 4'(I2C_BITS_PER_BYTE - 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_evt;

    i2c_slv_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       addressed_q, addressed_d;
    logic       busy_q, busy_d;
    logic       stop_q, stop_d;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .line_i  (scl),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .line_i  (sda),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        addressed_d = addressed_q;
        busy_d      = busy_q;
        stop_d      = 1'b0;

        if (start_det) begin
            busy_d      = 1'b1;
            addressed_d = 1'b0;
            cnt_d       = '0;
            sda_oe_d    = 1'b0;
            state_d     = ST_ADDR;
        end else if (stop_evt) begin
            stop_d      = 1'b1;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            sda_oe_d    = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && cnt_q < BYTE_CNT) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == BYTE_CNT) begin
                        rw_d = shift_q[0];
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            sda_oe_d = 1'b1;
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        addressed_d = 1'b1;
                        cnt_d       = '0;
                        if (rw_q == I2C_RW_READ) begin
                            tx_load_d = 1'b1;
                            shift_d   = tx_data;
                            sda_oe_d  = ~tx_data[7];
                            state_d   = ST_TX;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RX;
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise && cnt_q < BYTE_CNT) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == BYTE_CNT) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        sda_oe_d   = 1'b1;
                        state_d    = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = ST_RX;
                    end
                end
                // cnt counts bits already shifted out; bit 7 went out on the load.
                ST_TX: begin
                    if (scl_fall) begin
                        if (cnt_q == LAST_TX) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = ST_TX_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                // Any fall seen here follows an ACKed rise; a NACK leaves the state first.
                ST_TX_ACK: begin
                    if (scl_rise && sda_lvl) begin
                        addressed_d = 1'b0;
                        state_d     = ST_WAIT_STOP;
                    end else if (scl_fall) begin
                        tx_load_d = 1'b1;
                        shift_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                        cnt_d     = '0;
                        state_d   = ST_TX;
                    end
                end
                ST_WAIT_STOP: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            addressed_q <= 1'b0;
            busy_q      <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            addressed_q <= addressed_d;
            busy_q      <= busy_d;
            stop_q      <= stop_d;
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_load   = tx_load_q;
    assign addressed = addressed_q;
    assign busy      = busy_q;
    assign stop_det  = stop_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bus-master stimulus for i2c_slave_target; strobe outputs checked against an event scoreboard.
module tb_i2c_slave_target;

    localparam int HP = 10;
    localparam int EV_RX   = 0;
    localparam int EV_TXL  = 1;
    localparam int EV_STOP = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_load, addressed, busy, stop_det;
    wire        sda;

    int n_pass = 0;
    int n_total = 0;
    ev_t exp_q[$];

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_target #(.SLAVE_ADDR(7'h40)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_load   (tx_load),
        .addressed (addressed),
        .busy      (busy),
        .stop_det  (stop_det)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input logic [7:0] data);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got event %0d data %h, required none", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && (kind != EV_RX || e.data == data)) n_pass++;
            else $display("FAIL sb_event: got event %0d data %h, required event %0d data %h",
                          kind, data, e.kind, e.data);
        end
    endtask

    // Monitor: samples strobes on the falling clock edge, away from DUT updates.
    always @(negedge clk) begin
        if (rx_valid) sb_pop(EV_RX, rx_data);
        if (tx_load)  sb_pop(EV_TXL, 8'h00);
        if (stop_det) sb_pop(EV_STOP, 8'h00);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; wait_clk(HP);
        scl = 1'b1;   wait_clk(HP);
        m_low = 1'b1; wait_clk(HP);
        scl = 1'b0;   wait_clk(HP);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wait_clk(HP);
        scl = 1'b1;   wait_clk(HP);
        m_low = 1'b0; wait_clk(HP);
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b;  wait_clk(HP);
        scl = 1'b1;  wait_clk(HP);
        scl = 1'b0;  wait_clk(2);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; wait_clk(HP);
        scl = 1'b1;   wait_clk(HP / 2);
        b = sda;      wait_clk(HP / 2);
        scl = 1'b0;   wait_clk(2);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] rd;

        wait_clk(3);
        chk("reset_sda", sda, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_addressed", addressed, 1'b0);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_stop_det", stop_det, 1'b0);
        reset = 1'b0;
        wait_clk(5);

        // Single-byte write to own address
        expect_ev(EV_RX, 8'hA5);
        expect_ev(EV_STOP, 8'h00);
        bus_start();
        chk("wr_busy", busy, 1'b1);
        write_byte(8'h80, ack);
        chk("wr_addr_ack", ack, 1'b0);
        wait_clk(4);
        chk("wr_addressed", addressed, 1'b1);
        write_byte(8'hA5, ack);
        chk("wr_data_ack", ack, 1'b0);
        bus_stop();
        chk("wr_busy_after_stop", busy, 1'b0);
        chk("wr_rx_data", rx_data, 8'hA5);

        // Address mismatch: no ACK, no data strobe
        expect_ev(EV_STOP, 8'h00);
        bus_start();
        write_byte(8'h82, ack);
        chk("mis_addr_nack", ack, 1'b1);
        write_byte(8'h00, ack);
        chk("mis_data_nack", ack, 1'b1);
        chk("mis_addressed", addressed, 1'b0);
        chk("mis_busy", busy, 1'b1);
        bus_stop();

        // Two-byte read, master ACKs then NACKs
        expect_ev(EV_TXL, 8'h00);
        expect_ev(EV_TXL, 8'h00);
        expect_ev(EV_STOP, 8'h00);
        tx_data = 8'h3C;
        bus_start();
        write_byte(8'h81, ack);
        chk("rd_addr_ack", ack, 1'b0);
        read_byte(1'b0, rd);
        chk("rd_byte0", rd, 8'h3C);
        tx_data = 8'hC3;
        read_byte(1'b1, rd);
        chk("rd_byte1", rd, 8'hC3);
        wait_clk(4);
        chk("rd_addressed_after_nack", addressed, 1'b0);
        bus_stop();

        // Write then repeated START into a read
        expect_ev(EV_RX, 8'h11);
        expect_ev(EV_TXL, 8'h00);
        expect_ev(EV_STOP, 8'h00);
        tx_data = 8'h96;
        bus_start();
        write_byte(8'h80, ack);
        chk("rs_addr_ack", ack, 1'b0);
        write_byte(8'h11, ack);
        chk("rs_data_ack", ack, 1'b0);
        bus_start();
        chk("rs_addressed_cleared", addressed, 1'b0);
        write_byte(8'h81, ack);
        chk("rs_raddr_ack", ack, 1'b0);
        read_byte(1'b1, rd);
        chk("rs_read_byte", rd, 8'h96);
        chk("rs_rx_data_kept", rx_data, 8'h11);
        bus_stop();

        // Back-to-back write bytes in one transfer
        expect_ev(EV_RX, 8'h01);
        expect_ev(EV_RX, 8'h02);
        expect_ev(EV_RX, 8'h03);
        expect_ev(EV_STOP, 8'h00);
        bus_start();
        write_byte(8'h80, ack);
        chk("b2b_addr_ack", ack, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            write_byte(8'(i), ack);
            chk($sformatf("b2b_data%0d_ack", i), ack, 1'b0);
        end
        bus_stop();

        // Reset in the middle of a write byte
        bus_start();
        write_byte(8'h80, ack);
        chk("rst_addr_ack", ack, 1'b0);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        reset = 1'b1;
        wait_clk(1);
        chk("rst_sda", sda, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addressed", addressed, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        reset = 1'b0;
        wait_clk(5);
        expect_ev(EV_RX, 8'h5A);
        expect_ev(EV_STOP, 8'h00);
        bus_start();
        write_byte(8'h80, ack);
        chk("post_rst_addr_ack", ack, 1'b0);
        write_byte(8'h5A, ack);
        chk("post_rst_data_ack", ack, 1'b0);
        bus_stop();
        chk("post_rst_rx_data", rx_data, 8'h5A);

        wait_clk(10);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
